// File: rtl/pipeline_status_pkg.sv
// rtl/pipeline_status_pkg.sv - shared pipeline handshake types and NOP encoding
package pipeline_status;

  typedef enum logic [3:0] {
    BUBBLE           = 4'd0,
    VALID            = 4'd1,
    FETCH_FAULT      = 4'd2,
    FETCH_MISALIGNED = 4'd3
  } forwards_t;

  typedef enum logic [1:0] {
    READY = 2'd0,
    STALL = 2'd1,
    JUMP  = 2'd2
  } backwards_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - one-entry holding slot for a response that decode could not take
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  input  logic        err_i,
  output logic        valid_o,
  output logic [31:0] data_o,
  output logic        err_o
);

  logic        valid_q;
  logic [31:0] data_q;
  logic        err_q;

  // clear wins so a redirect can never leak a stale instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      err_q   <= err_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM with single outstanding request and skid slot
// FETCH_PERF_CNT_EN adds fetch_count_o / bubble_count_o event counters.
module fetch_stage
  import pipeline_status::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  back_status_i,
  input  logic [31:0] jump_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [3:0]  fwd_status_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] bubble_count_o
`endif
);

  typedef enum logic [2:0] {FETCH, WAIT, HOLD, DISCARD, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  forwards_t   status_q, status_d;
  logic        pend_mis_q, pend_mis_d;

  logic        skid_push, skid_pop, skid_clear;
  logic        skid_valid, skid_err;
  logic [31:0] skid_data;

  logic is_ready, is_stall, is_jump, granted;

  assign is_jump  = (back_status_i == JUMP);
  assign is_ready = (back_status_i == READY);
  assign is_stall = !is_jump && !is_ready;
  assign granted  = req_q && imem_gnt_i;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .clear_i (skid_clear),
    .data_i  (imem_rdata_i),
    .err_i   (imem_err_i),
    .valid_o (skid_valid),
    .data_o  (skid_data),
    .err_o   (skid_err)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    status_d   = status_q;
    pend_mis_d = pend_mis_q;
    skid_push  = 1'b0;
    skid_pop   = 1'b0;
    skid_clear = 1'b0;

    if (is_jump) begin
      pc_d       = jump_target_i;
      skid_clear = 1'b1;
      pend_mis_d = 1'b0;
      instr_d    = NOP;
      status_d   = BUBBLE;
      case (state_q)
        FETCH:   state_d = granted ? DISCARD : FETCH;
        WAIT,
        DISCARD: state_d = imem_rvalid_i ? FETCH : DISCARD;
        default: state_d = FETCH;
      endcase
    end else begin
      if (is_ready) begin
        instr_d  = NOP;
        status_d = BUBBLE;
      end
      case (state_q)
        FETCH: begin
          if (pc_q[1:0] != 2'b00) begin
            state_d = HALT;
            if (is_ready) begin
              pc_out_d = pc_q;
              status_d = FETCH_MISALIGNED;
            end else begin
              pend_mis_d = 1'b1;
            end
          end else if (granted) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            state_d = imem_err_i ? HALT : HOLD;
            if (is_ready) begin
              instr_d  = imem_rdata_i;
              pc_out_d = pc_q;
              status_d = imem_err_i ? FETCH_FAULT : VALID;
              if (!imem_err_i) begin
                pc_d    = pc_q + 32'd4;
                state_d = FETCH;
              end
            end else begin
              skid_push = 1'b1;
            end
          end
        end
        HOLD: begin
          if (is_ready) begin
            instr_d  = skid_data;
            pc_out_d = pc_q;
            status_d = skid_err ? FETCH_FAULT : VALID;
            pc_d     = pc_q + 32'd4;
            skid_pop = 1'b1;
            state_d  = FETCH;
          end
        end
        DISCARD: begin
          if (imem_rvalid_i) state_d = FETCH;
        end
        HALT: begin
          // a fault/misalignment seen under STALL is delivered here once decode is ready
          if (is_ready && pend_mis_q) begin
            pc_out_d   = pc_q;
            status_d   = FETCH_MISALIGNED;
            pend_mis_d = 1'b0;
          end else if (is_ready && skid_valid) begin
            instr_d  = skid_data;
            pc_out_d = pc_q;
            status_d = FETCH_FAULT;
            skid_pop = 1'b1;
          end
        end
        default: state_d = HALT;
      endcase
    end

    req_d = (state_d == FETCH) && (pc_d[1:0] == 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_VECTOR;
      req_q      <= 1'b0;
      instr_q    <= NOP;
      pc_out_q   <= '0;
      status_q   <= BUBBLE;
      pend_mis_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      status_q   <= status_d;
      pend_mis_q <= pend_mis_d;
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign instr_o      = instr_q;
  assign pc_o         = pc_out_q;
  assign fwd_status_o = status_q;

`ifdef FETCH_PERF_CNT_EN
  logic        emit;
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  assign emit = is_ready || is_jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (emit && status_d == VALID)  fetch_cnt_q  <= fetch_cnt_q + 32'd1;
      if (emit && status_d == BUBBLE) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count_o  = fetch_cnt_q;
  assign bubble_count_o = bubble_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 back_status_i  input  2 (backwards_t)  SHALL be the READY/STALL/JUMP from decode.
REQ-005 jump_target_i  input  32  SHALL be the redirect address, sampled only when back_status_i==JUMP.
REQ-006 imem_req_o  output  1  SHALL be the instruction memory request strobe.
REQ-007 imem_addr_o  output  32  SHALL be the request address, always equal to the internal pc.
REQ-008 imem_gnt_i  input  1  SHALL be the request accept; a request completes on the cycle req&gnt.
REQ-009 imem_rvalid_i / imem_rdata_i / imem_err_i  input  1/32/1  SHALL be the response valid, data and bus error.
REQ-010 instr_o  output  32  SHALL be the registered instruction to decode.
REQ-011 pc_o  output  32  SHALL be the address of instr_o.
REQ-012 fwd_status_o  output  4 (forwards_t)  SHALL be the registered status to decode.

Function
REQ-013 FSM states: FETCH, WAIT, HOLD, DISCARD, HALT; at most one request outstanding.
REQ-014 FETCH: imem_req_o=1 if pc[1:0]==0; on gnt go WAIT; misaligned pc SHALL not request, SHALL emit FETCH_MISALIGNED with pc_o=pc, go HALT.
REQ-015 WAIT: on rvalid with back_status_i==READY, register instr_o=rdata, pc_o=pc, status VALID (FETCH_FAULT if err), pc<=pc+4 (wraps mod 2^32), go FETCH.
REQ-016 WAIT: on rvalid with STALL, store response in one-entry skid buffer, go HOLD; output registers unchanged.
REQ-017 HOLD: no request; on READY, skid contents move to outputs and the FSM goes to FETCH, with pc advanced once only.
REQ-018 Any response carrying err SHALL emit FETCH_FAULT then go HALT; HALT issues no requests until JUMP.
REQ-019 While back_status_i==STALL, instr_o/pc_o/fwd_status_o SHALL hold; FETCH may still issue a request.
REQ-020 Cycles with READY and no new instruction SHALL drive fwd_status_o=BUBBLE, instr_o=NOP.
REQ-021 JUMP has priority over every event: pc<=jump_target_i, skid cleared, outputs become BUBBLE/NOP next cycle.
REQ-022 JUMP in WAIT, or in FETCH on the same cycle as req&gnt, SHALL go DISCARD; the next rvalid is dropped, then FETCH at the new pc.
REQ-023 JUMP in FETCH/HOLD/HALT/DISCARD SHALL go FETCH (DISCARD stays DISCARD if its response is still pending).
REQ-024 Fault and misaligned statuses SHALL ignore STALL for entry into HALT but still obey output hold (REQ-019).

Reset
REQ-025 Reset SHALL set pc=RESET_VECTOR, state FETCH, skid empty, imem_req_o=0 during reset, instr_o=NOP, pc_o=0, fwd_status_o=BUBBLE.
REQ-026 Reset mid-transaction SHALL abandon the outstanding request; first rvalid after reset without a prior grant is ignored.

Configuration
REQ-027 With FETCH_PERF_CNT_EN defined, outputs fetch_count_o[31:0] (VALID emitted) and bubble_count_o[31:0] (BUBBLE emitted) SHALL exist, reset to 0, wrap at 2^32.
REQ-028 Without FETCH_PERF_CNT_EN, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-029 forwards_t, backwards_t and the constant NOP=32'h0000_0013 SHALL live in the shared pipeline_status package; FSM state enum is local.
REQ-030 The skid buffer SHALL be a sub-module fetch_skid_buffer (32-bit data + err, one entry, push/pop/clear).

Verification
REQ-031 Reset release, gnt=1, rvalid next cycle with rdata=32'h0010_0093, READY -> instr_o=32'h0010_0093, pc_o=0, VALID; next addr 4.
REQ-032 STALL asserted while response arrives -> outputs hold 3 cycles, HOLD state; READY -> buffered instruction appears once, no duplicate.
REQ-033 JUMP to 32'h0000_0100 while WAIT -> response dropped, BUBBLE emitted, next imem_addr_o=32'h100.
REQ-034 JUMP to 32'h0000_0102 -> no request, FETCH_MISALIGNED with pc_o=32'h102; JUMP to 32'h200 resumes fetching.
REQ-035 rvalid with err=1 at pc 32'h8 -> FETCH_FAULT, pc_o=8, imem_req_o stays 0 until JUMP.
REQ-036 pc=32'hFFFF_FFFC fetch completes -> next imem_addr_o=32'h0; rst_n low mid-WAIT -> outputs at reset values immediately.
